// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared ALUop encodings and MULTU/DIVU select for the muldiv sequencer
//
// Purpose: constants shared by muldiv_seq and the instruction decoder.
//   ALU_ADDU / ALU_SUBU mirror the shared ALUop encodings.
//   MULDIV_OP_MULTU / MULDIV_OP_DIVU select the operation on the 1-bit op port.
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;

  localparam logic MULDIV_OP_MULTU = 1'b0;
  localparam logic MULDIV_OP_DIVU  = 1'b1;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULTU/DIVU sequencer driving the shared execute-stage ALU
//
// Purpose: runs shift-add multiply or restoring divide, one step per cycle,
// through the external ALU, and holds the architectural HI/LO registers.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start, op       request and operation select (0 = MULTU, 1 = DIVU)
//   rs_val, rt_val  multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we    MTHI/MTLO strobes, wdata is the data
//   busy, done      busy while stepping; done one-cycle pulse with HI/LO valid
//   hi, lo          HI/LO registers
//   alu_A, alu_B    ALU operands, alu_op ALUop, alu_out combinational ALU result
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] alu_A,
  output logic [XLEN-1:0] alu_B,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t          state, state_n;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN-1:0] opnd, opnd_n;   // multiplicand for MULTU, divisor for DIVU
  logic            op_q, op_n;
  logic [CW-1:0]   count, count_n;
  logic [XLEN-1:0] sh;
  logic            carry;
  logic            ge;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      op_q  <= MULDIV_OP_MULTU;
      count <= '0;
    end else begin
      state <= state_n;
      hi    <= hi_n;
      lo    <= lo_n;
      opnd  <= opnd_n;
      op_q  <= op_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    hi_n    = hi;
    lo_n    = lo;
    opnd_n  = opnd;
    op_n    = op_q;
    count_n = count;
    alu_A   = '0;
    alu_B   = '0;
    alu_op  = ALU_ADDU;
    // Divide step: partial remainder shifted left, pulling in the next dividend bit.
    sh      = {hi[XLEN-2:0], lo[XLEN-1]};
    carry   = 1'b0;
    ge      = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          // start wins over a simultaneous MTHI/MTLO
          op_n    = op;
          hi_n    = '0;
          lo_n    = (op == MULDIV_OP_MULTU) ? rt_val : rs_val;
          opnd_n  = (op == MULDIV_OP_MULTU) ? rs_val : rt_val;
          count_n = '0;
          state_n = S_RUN;
        end else begin
          if (hi_we) hi_n = wdata;
          if (lo_we) lo_n = wdata;
          if (state == S_DONE) state_n = S_IDLE;
        end
      end

      S_RUN: begin
        count_n = count + 1'b1;
        if (op_q == MULDIV_OP_MULTU) begin
          alu_op = ALU_ADDU;
          alu_A  = hi;
          alu_B  = lo[0] ? opnd : '0;
          // ADDU wraps; a result below hi means the 33rd bit was set
          carry  = (alu_out < hi);
          hi_n   = {carry, alu_out[XLEN-1:1]};
          lo_n   = {alu_out[0], lo[XLEN-1:1]};
        end else begin
          alu_op = ALU_SUBU;
          alu_A  = sh;
          alu_B  = opnd;
          // hi[31] set means the true shifted value is >= 2^32, so it always exceeds the divisor
          ge     = hi[XLEN-1] | (sh >= opnd);
          if (ge) begin
            hi_n = alu_out;
            lo_n = {lo[XLEN-2:0], 1'b1};
          end else begin
            hi_n = sh;
            lo_n = {lo[XLEN-2:0], 1'b0};
          end
        end
        if (count == LAST) state_n = S_DONE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
